// File: rtl/ifetch_ctrl_pkg.sv
// Shared uP16 fetch definitions: default widths and the fetch-sequencer state encoding.
package ifetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned ISIZE_DEF  = 18;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_ctrl.sv
// uP16 instruction-fetch sequencer: owns the PC, addresses the 1-cycle-latency ROM,
// and presents fetched words downstream with a valid/ready handshake.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       ISIZE     = ISIZE_DEF,
  parameter int unsigned       CNT_W     = CNT_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              Clk_In,
  input  logic              Rst_n_In,
  input  logic              Start_In,
  input  logic              Halt_In,
  input  logic              Branch_In,
  input  logic [ADDR_W-1:0] Branch_Target_In,
  input  logic              Ready_In,
  input  logic [ISIZE-1:0]  Mem_Data_In,
  output logic [ADDR_W-1:0] Mem_Add_Out,
  output logic [ISIZE-1:0]  Instr_Out,
  output logic [ADDR_W-1:0] Instr_PC_Out,
  output logic              Instr_Valid_Out,
  output logic              Busy_Out,
  output logic [CNT_W-1:0]  Fetch_Count_Out
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, mem_add;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept;

  assign accept = (state == ST_RUN) & Ready_In;

  // pc always tracks the address presented last cycle, i.e. the word now on Mem_Data_In
  always_ff @(posedge Clk_In or negedge Rst_n_In) begin
    if (!Rst_n_In) begin
      state <= ST_IDLE;
      pc    <= RESET_VEC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= mem_add;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and next-address selection
  always_comb begin
    state_nxt = state;
    mem_add   = pc;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        mem_add = RESET_VEC;
        if (Start_In) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        if (Branch_In) mem_add = Branch_Target_In;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (Branch_In) begin
          mem_add = Branch_Target_In;
        end else if (accept) begin
          mem_add = ADDR_W'(pc + 1'b1);
          cnt_nxt = CNT_W'(cnt + 1'b1);
        end
        if (Halt_In) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (Start_In) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Mem_Add_Out     = mem_add;
  assign Instr_Out       = Mem_Data_In;
  assign Instr_PC_Out    = pc;
  assign Instr_Valid_Out = (state == ST_RUN);
  assign Busy_Out        = (state == ST_PRIME) | (state == ST_RUN);
  assign Fetch_Count_Out = cnt;

endmodule
